// File: rtl/decoder_nx2pn_pipe_if.sv
// decoder_nx2pn_pipe_if: index in / one-hot out valid-ready bus.
// THERM member present only with DECODER_NX2PN_THERM_EN defined.
interface decoder_nx2pn_pipe_if #(
  parameter int N = 5
);
  localparam int W = 1 << N;

  logic [N-1:0] in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
`ifdef DECODER_NX2PN_THERM_EN
  logic [W-1:0] therm;

  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid, therm
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid, therm
  );
`else
  modport master (
    output in, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in, in_valid, out_ready,
    output in_ready, out, out_valid
  );
`endif
endinterface

// File: rtl/decoder_nx2pn_pipe.sv
// decoder_nx2pn_pipe: registered N-to-2**N one-hot decoder, 2-entry skid.
// Optional thermometer output via DECODER_NX2PN_THERM_EN.
module decoder_nx2pn_pipe #(
  parameter int N = 5
) (
  input logic                 CLK,
  input logic                 RSTn,
  decoder_nx2pn_pipe_if.slave bus
);
  localparam int W = 1 << N;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         valid_q;
  logic         rdy_q;
  logic [W-1:0] dec_oh;
  logic         acc;
  logic         tak;
  logic         ld_main;
  logic         ld_skid;
  logic         mv_skid;

  assign acc = bus.in_valid & rdy_q;
  assign tak = valid_q & bus.out_ready;

  // one-hot decode of the incoming index
  always_comb begin
    dec_oh = '0;
    dec_oh[bus.in] = 1'b1;
  end

  // next buffer state and which register loads
  always_comb begin
    state_nx = state;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    mv_skid  = 1'b0;
    unique case (state)
      EMPTY: begin
        if (acc) begin
          state_nx = ONE;
          ld_main  = 1'b1;
        end
      end
      ONE: begin
        if (acc && tak) begin
          ld_main = 1'b1;
        end else if (acc) begin
          state_nx = FULL;
          ld_skid  = 1'b1;
        end else if (tak) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (tak) begin
          state_nx = ONE;
          mv_skid  = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // state, flags and one-hot storage
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_nx;
      valid_q <= (state_nx != EMPTY);
      rdy_q   <= (state_nx != FULL);
      if (ld_main)
        main_q <= dec_oh;
      else if (mv_skid)
        main_q <= skid_q;
      if (ld_skid)
        skid_q <= dec_oh;
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out       = main_q;
  assign bus.out_valid = valid_q;

`ifdef DECODER_NX2PN_THERM_EN
  logic [W-1:0] dec_th;
  logic [W-1:0] main_t;
  logic [W-1:0] skid_t;

  assign dec_th = {W{1'b1}} << bus.in;

  // thermometer words ride alongside the one-hot words
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      main_t <= '0;
      skid_t <= '0;
    end else begin
      if (ld_main)
        main_t <= dec_th;
      else if (mv_skid)
        main_t <= skid_t;
      if (ld_skid)
        skid_t <= dec_th;
    end
  end

  assign bus.therm = main_t;
`endif
endmodule

// File: tb/tb_decoder_nx2pn_pipe.sv
// tb_decoder_nx2pn_pipe: scoreboarded bench for decoder_nx2pn_pipe.
// Also builds an N=1 instance for the smallest-width boundary.
module tb_decoder_nx2pn_pipe;
  localparam int N = 5;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   sb[$];
  int   mon_e;

  always #5 clk = ~clk;

  decoder_nx2pn_pipe_if #(.N(N)) bus ();
  decoder_nx2pn_pipe_if #(.N(1)) bus1 ();

  decoder_nx2pn_pipe #(.N(N)) dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  decoder_nx2pn_pipe #(.N(1)) dut1 (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus1)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] oh(int i);
    logic [63:0] r;
    r = 64'd1 << i;
    return r;
  endfunction

  function automatic logic [63:0] th(int i);
    logic [31:0] t;
    t = 32'hFFFF_FFFF << i;
    return {32'd0, t};
  endfunction

  // transfers are observed mid-cycle: pop on output, push on input
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("sb_out", 64'(bus.out), oh(mon_e));
          chk("popcount", 64'($countones(bus.out)), 1);
`ifdef DECODER_NX2PN_THERM_EN
          chk("sb_therm", 64'(bus.therm), th(mon_e));
`endif
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(int'(bus.in));
    end
  end

  task automatic send(int v);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in = N'(v);
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_acc", 64'(ok), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in = 5'd3;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    bus1.in = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;

    // reset with input offered
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ovalid", 64'(bus.out_valid), 0);
    chk("rst_iready", 64'(bus.in_ready), 1);
    chk("rst_out", 64'(bus.out), 0);
`ifdef DECODER_NX2PN_THERM_EN
    chk("rst_therm", 64'(bus.therm), 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_out", 64'(bus.out), 64'h0000_0008);
    chk("first_ovalid", 64'(bus.out_valid), 1);
    drain();

    // streaming sweep
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = 1'b1;
      bus.in = 5'(i);
      @(posedge clk);
      #1;
      chk("stream_out", 64'(bus.out), oh(i));
      chk("stream_ovalid", 64'(bus.out_valid), 1);
      chk("stream_iready", 64'(bus.in_ready), 1);
`ifdef DECODER_NX2PN_THERM_EN
      chk("stream_therm", 64'(bus.therm), th(i));
`endif
    end
    drain();

    // backpressure: 5 and 6 taken, 7 held off
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in = 5'd5;
    @(posedge clk);
    #1;
    bus.in = 5'd6;
    @(posedge clk);
    #1;
    chk("bp_iready0", 64'(bus.in_ready), 0);
    bus.in = 5'd7;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_hold_rdy", 64'(bus.in_ready), 0);
      chk("bp_hold_out", 64'(bus.out), oh(5));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_out6", 64'(bus.out), oh(6));
    chk("bp_drain_rdy", 64'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    chk("bp_out7", 64'(bus.out), oh(7));
    drain();

    // stall stability
    bus.out_ready = 1'b0;
    send(9);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("stall_out", 64'(bus.out), oh(9));
      chk("stall_ovalid", 64'(bus.out_valid), 1);
    end
    drain();

    // random traffic
    for (int c = 0; c < 10000; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in = 5'($urandom_range(0, 31));
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain();
    chk("rand_sb_empty", 64'(sb.size()), 0);

    // boundary indices
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in = 5'd0;
    @(posedge clk);
    #1;
    chk("idx0_out", 64'(bus.out), 64'h1);
`ifdef DECODER_NX2PN_THERM_EN
    chk("idx0_therm", 64'(bus.therm), 64'hFFFF_FFFF);
`endif
    bus.in = 5'd31;
    @(posedge clk);
    #1;
    chk("idx31_out", 64'(bus.out), 64'h8000_0000);
`ifdef DECODER_NX2PN_THERM_EN
    chk("idx31_therm", 64'(bus.therm), 64'h8000_0000);
`endif
    bus.in_valid = 1'b0;
    bus1.in = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("n1_out", 64'(bus1.out), 64'h2);
    chk("n1_ovalid", 64'(bus1.out_valid), 1);
    bus1.in_valid = 1'b0;
    drain();

    // mid-operation reset from FULL
    bus.out_ready = 1'b0;
    send(10);
    send(11);
    chk("full_iready", 64'(bus.in_ready), 0);
    chk("full_ovalid", 64'(bus.out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_ovalid", 64'(bus.out_valid), 0);
    chk("mrst_iready", 64'(bus.in_ready), 1);
    chk("mrst_out", 64'(bus.out), 0);
    sb.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("mrst_nostale", 64'(bus.out_valid), 0);
    end
    chk("mrst_sb_empty", 64'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
